// File: rtl/question_db_rnd.sv
// Question store for the factorization game.
// Holds DEPTH question words {BCD number[23:12], factor codes[11:0]} and
// serves one per request, either by direct index or by an LFSR pick that
// never repeats the previously delivered question. Runtime writable.
module question_db_rnd #(
  parameter int          DEPTH = 16,
  parameter int          AW    = 4,
  parameter logic [15:0] SEED  = 16'hACE1
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          REQ,
  input  logic          MODE,
  input  logic [AW-1:0] NUM_IN,
  input  logic          WE,
  input  logic [AW-1:0] WADDR,
  input  logic [23:0]   WDATA,
  output logic [23:0]   QUESTION,
  output logic [AW-1:0] Q_IDX,
  output logic          VALID,
  output logic          BUSY,
  output logic          ERR
);

  typedef enum logic [1:0] {IDLE, SEARCH, OUT} state_t;

  // DEPTH widened by one bit so index compares stay width-matched even when
  // DEPTH == 2**AW.
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
  localparam int          NENT    = 2**AW;

  function automatic logic [23:0] def_entry(input int i);
    case (i)
      0:       def_entry = 24'h030123;
      1:       def_entry = 24'h027222;
      2:       def_entry = 24'h042124;
      3:       def_entry = 24'h012112;
      4:       def_entry = 24'h105234;
      5:       def_entry = 24'h066125;
      6:       def_entry = 24'h070134;
      7:       def_entry = 24'h045223;
      8:       def_entry = 24'h098144;
      9:       def_entry = 24'h110135;
      10:      def_entry = 24'h078126;
      11:      def_entry = 24'h050133;
      12:      def_entry = 24'h102127;
      13:      def_entry = 24'h114128;
      14:      def_entry = 24'h138129;
      15:      def_entry = 24'h125333;
      default: def_entry = 24'h000000;
    endcase
  endfunction

  state_t        state, state_n;
  logic [AW-1:0] idx, idx_n;
  logic [AW-1:0] last;
  logic [15:0]   lfsr;
  logic [23:0]   tab [NENT];
  logic [AW-1:0] cand;
  logic          num_ok, waddr_ok, cand_ok, err_n;

  assign cand     = lfsr[AW-1:0];
  assign num_ok   = ({1'b0, NUM_IN} < DEPTH_W);
  assign waddr_ok = ({1'b0, WADDR}  < DEPTH_W);
  // Random pick must be in range and differ from the last delivered index.
  assign cand_ok  = ({1'b0, cand} < DEPTH_W) && (cand != last);
  assign BUSY     = (state != IDLE);

  // Free-running Fibonacci LFSR, taps 16,14,13,11; steps every cycle.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) lfsr <= SEED;
    else        lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
  end

  // State and latched index registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
    end
  end

  // Next-state: direct requests jump to OUT, random ones search first.
  always_comb begin
    state_n = state;
    idx_n   = idx;
    case (state)
      IDLE: begin
        if (REQ) begin
          if (MODE) begin
            state_n = SEARCH;
          end else if (num_ok) begin
            idx_n   = NUM_IN;
            state_n = OUT;
          end
        end
      end
      SEARCH: begin
        if (cand_ok) begin
          idx_n   = cand;
          state_n = OUT;
        end
      end
      OUT:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // A bad write and a bad request in the same cycle still give one pulse.
  always_comb begin
    err_n = (WE && !waddr_ok) || ((state == IDLE) && REQ && !MODE && !num_ok);
  end

  // Question table; the OUT read uses the pre-edge contents, so a write to
  // the same entry on that edge is seen only by later requests.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < NENT; i++) tab[i] <= def_entry(i);
    end else if (WE && waddr_ok) begin
      tab[WADDR] <= WDATA;
    end
  end

  // Delivery registers: load on OUT, VALID/ERR are single-cycle pulses.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      QUESTION <= '0;
      Q_IDX    <= '0;
      last     <= '1;
      VALID    <= 1'b0;
      ERR      <= 1'b0;
    end else begin
      VALID <= (state == OUT);
      ERR   <= err_n;
      if (state == OUT) begin
        QUESTION <= tab[idx];
        Q_IDX    <= idx;
        last     <= idx;
      end
    end
  end

endmodule
